// File: rtl/conv_seq_pkg.sv
// conv_seq_pkg: shared types and constants for the convolution frame sequencer.
//   seq_state_t : sequencer states (IDLE -> LOAD -> DRAIN -> CLEAR -> IDLE)
//   LANE_W/LANE_N/RES_W : lane width, lane count and engine result width
package conv_seq_pkg;

  localparam int unsigned LANE_W = 16;
  localparam int unsigned LANE_N = 4;
  localparam int unsigned RES_W  = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_CLEAR
  } seq_state_t;

  typedef logic signed [LANE_W-1:0] lane_t;

endpackage

// File: rtl/conv_seq_ctrl_fifo.sv
// conv_res_fifo: first-word fall-through result FIFO.
//   clk, rst      : clock, asynchronous active-high reset (empties the FIFO)
//   push, din     : write request and data; dropped when full unless popped
//                   in the same cycle
//   pop, dout     : read acknowledge and head-of-queue data (valid when !empty)
//   full, empty   : occupancy flags
//   drop          : high in a cycle whose push is being discarded
// DEPTH must be a power of two, at least 2.
module conv_res_fifo
  import conv_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = RES_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int unsigned      AW       = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]    PTR_ONE  = 1;
  localparam logic [AW:0]      CNT_ONE  = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign rd_en = pop && !empty;
  // When full, the slot under wr_ptr is the head being popped this cycle,
  // so the write may land there safely.
  assign wr_en = push && (!full || rd_en);
  assign drop  = push && !wr_en;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: frame sequencer for the 4-lane 64-tap convolution engine.
// Streams cfg_len input beats into the engine, captures engine results into
// a FWFT result FIFO, then pulses the engine reset for one cycle.
//   clk, rst                 : clock, asynchronous active-high reset
//   start, cfg_len           : frame request (IDLE only) and beat count
//   busy, frame_done         : not-IDLE flag, end-of-frame pulse
//   s_valid/s_ready/s_data   : input beat stream (lane0 = [63:48])
//   eng_rst, eng_op_st       : engine reset / run
//   eng_a0..eng_a3           : registered engine lane inputs
//   eng_dout/eng_st_out/eng_done : engine result, result-valid, done
//   m_valid/m_ready/m_data   : result stream
//   res_cnt                  : results captured this frame (saturating)
//   ovf_err/udr_err/tmo_err  : sticky overflow / underrun / timeout flags
// Optional: define CONV_SEQ_TIMEOUT_EN to enable the DRAIN watchdog
// (DRAIN_MAX cycles); otherwise DRAIN waits for eng_done indefinitely.
module conv_seq_ctrl
  import conv_seq_pkg::*;
#(
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned RES_DEPTH = 8,
  parameter int unsigned DRAIN_MAX = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              busy,
  output logic              frame_done,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [RES_W-1:0]  s_data,
  output logic              eng_rst,
  output logic              eng_op_st,
  output logic [LANE_W-1:0] eng_a0,
  output logic [LANE_W-1:0] eng_a1,
  output logic [LANE_W-1:0] eng_a2,
  output logic [LANE_W-1:0] eng_a3,
  input  logic [RES_W-1:0]  eng_dout,
  input  logic              eng_st_out,
  input  logic              eng_done,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [RES_W-1:0]  m_data,
  output logic [LEN_W:0]    res_cnt,
  output logic              ovf_err,
  output logic              udr_err,
  output logic              tmo_err
);

  if (RES_DEPTH < 2 || (RES_DEPTH & (RES_DEPTH - 1)) != 0 || DRAIN_MAX < 1) begin : g_param_chk
    $error("conv_seq_ctrl: RES_DEPTH must be a power of two >= 2 and DRAIN_MAX >= 1");
  end

  localparam logic [LEN_W-1:0] LEN_ONE = 1;
  localparam logic [LEN_W:0]   CNT_ONE = 1;

  seq_state_t       state_q;
  seq_state_t       state_d;
  logic [LEN_W-1:0] rem_q;
  lane_t            lane_q [LANE_N];
  logic             accept;
  logic             last_beat;
  logic             capture;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_drop;
  logic             drain_tmo;

  assign accept    = (state_q == ST_IDLE) && start && (cfg_len != '0);
  assign last_beat = (rem_q == LEN_ONE);
  assign capture   = ((state_q == ST_LOAD) || (state_q == ST_DRAIN)) &&
                     eng_st_out && !eng_done;
  assign m_valid   = !fifo_empty;
  assign pop       = m_valid && m_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_LOAD;
      ST_LOAD:  if (last_beat) state_d = ST_DRAIN;
      ST_DRAIN: if (eng_done || drain_tmo) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy       = 1'b0;
    s_ready    = 1'b0;
    eng_op_st  = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_LOAD: begin
        busy      = 1'b1;
        s_ready   = 1'b1;
        eng_op_st = 1'b1;
      end
      ST_DRAIN: begin
        busy      = 1'b1;
        eng_op_st = 1'b1;
      end
      ST_CLEAR: begin
        busy       = 1'b1;
        frame_done = 1'b1;
      end
      default: ;
    endcase
    eng_rst = rst || (state_q == ST_CLEAR);
  end

  // Remaining beats in the frame; LOAD consumes one beat per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     rem_q <= '0;
    else if (accept)             rem_q <= cfg_len;
    else if (state_q == ST_LOAD) rem_q <= rem_q - LEN_ONE;
  end

  // Lane registers: a missing beat feeds zeros since the engine cannot stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LANE_N; i++) lane_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < LANE_N; i++) begin
        lane_q[i] <= (state_q == ST_LOAD && s_valid) ?
                     s_data[RES_W-1-i*LANE_W -: LANE_W] : '0;
      end
    end
  end

  assign eng_a0 = lane_q[0];
  assign eng_a1 = lane_q[1];
  assign eng_a2 = lane_q[2];
  assign eng_a3 = lane_q[3];

  // Result counter and sticky error flags, cleared when a frame is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_cnt <= '0;
      ovf_err <= 1'b0;
      udr_err <= 1'b0;
    end else if (accept) begin
      res_cnt <= '0;
      ovf_err <= 1'b0;
      udr_err <= 1'b0;
    end else begin
      if (capture && res_cnt != '1) res_cnt <= res_cnt + CNT_ONE;
      if (fifo_drop)                ovf_err <= 1'b1;
      if (state_q == ST_LOAD && !s_valid) udr_err <= 1'b1;
    end
  end

`ifdef CONV_SEQ_TIMEOUT_EN
  localparam int unsigned DC_W = $clog2(DRAIN_MAX) + 1;
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DRAIN_MAX - 1);
  localparam logic [DC_W-1:0] DC_ONE  = 1;

  logic [DC_W-1:0] drain_cnt_q;
  logic            tmo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      drain_cnt_q <= '0;
    else if (state_q != ST_DRAIN) drain_cnt_q <= '0;
    else                          drain_cnt_q <= drain_cnt_q + DC_ONE;
  end

  assign drain_tmo = (state_q == ST_DRAIN) && !eng_done && (drain_cnt_q == DC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            tmo_q <= 1'b0;
    else if (accept)    tmo_q <= 1'b0;
    else if (drain_tmo) tmo_q <= 1'b1;
  end

  assign tmo_err = tmo_q;
`else
  assign drain_tmo = 1'b0;
  assign tmo_err   = 1'b0;
`endif

  conv_res_fifo #(
    .DEPTH (RES_DEPTH),
    .WIDTH (RES_W)
  ) u_res_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .din   (eng_dout),
    .pop   (pop),
    .dout  (m_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: self-checking bench for conv_seq_ctrl. The engine is
// modelled by driving eng_* directly cycle by cycle. Inputs change just after
// the falling edge and outputs are sampled 1 ns later.
module tb_conv_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  cfg_len;
  logic        busy, frame_done;
  logic        s_valid, s_ready;
  logic [63:0] s_data;
  logic        eng_rst, eng_op_st;
  logic [15:0] eng_a0, eng_a1, eng_a2, eng_a3;
  logic [63:0] eng_dout;
  logic        eng_st_out, eng_done;
  logic        m_valid, m_ready;
  logic [63:0] m_data;
  logic [8:0]  res_cnt;
  logic        ovf_err, udr_err, tmo_err;

  int n_chk  = 0;
  int n_pass = 0;

  conv_seq_ctrl #(
    .LEN_W     (8),
    .RES_DEPTH (8),
    .DRAIN_MAX (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_len    (cfg_len),
    .busy       (busy),
    .frame_done (frame_done),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .eng_rst    (eng_rst),
    .eng_op_st  (eng_op_st),
    .eng_a0     (eng_a0),
    .eng_a1     (eng_a1),
    .eng_a2     (eng_a2),
    .eng_a3     (eng_a3),
    .eng_dout   (eng_dout),
    .eng_st_out (eng_st_out),
    .eng_done   (eng_done),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .res_cnt    (res_cnt),
    .ovf_err    (ovf_err),
    .udr_err    (udr_err),
    .tmo_err    (tmo_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [7:0]  len;
    logic        sv;
    logic [15:0] sd;
    logic        st;
    logic        dn;
    logic [63:0] dout;
    logic        mr;
    logic        e_busy;
    logic        e_sr;
    logic        e_op;
    logic        e_erst;
    logic        e_fd;
    logic        e_mv;
    logic [63:0] e_md;
    logic [15:0] e_a;
  } vec_t;

  vec_t tv [9];

  // Distinct per-lane values so a lane swap is visible.
  function automatic logic [15:0] lane_val(input logic [15:0] v, input int k);
    return 16'(v * 16'(k + 1));
  endfunction

  function automatic logic [63:0] mk_data(input logic [15:0] v);
    return {lane_val(v, 0), lane_val(v, 1), lane_val(v, 2), lane_val(v, 3)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chk_lanes(input string name, input logic [15:0] v);
    chk({name, ".a0"}, 64'(eng_a0), 64'(lane_val(v, 0)));
    chk({name, ".a1"}, 64'(eng_a1), 64'(lane_val(v, 1)));
    chk({name, ".a2"}, 64'(eng_a2), 64'(lane_val(v, 2)));
    chk({name, ".a3"}, 64'(eng_a3), 64'(lane_val(v, 3)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [63:0] exp_q [8];
    int hs;

    // start len sv sd st dn dout mr | busy sr op erst fd mv md a
    tv[0] = '{1, 4, 1, 16'h0000, 0, 0, 64'h0, 1,  0, 0, 0, 0, 0, 0, 64'h0, 16'h0};
    tv[1] = '{0, 0, 1, 16'h0001, 0, 0, 64'h0, 1,  1, 1, 1, 0, 0, 0, 64'h0, 16'h0};
    tv[2] = '{0, 0, 1, 16'h0002, 0, 0, 64'h0, 1,  1, 1, 1, 0, 0, 0, 64'h0, 16'h1};
    tv[3] = '{0, 0, 1, 16'h0003, 1, 0, 64'hA, 1,  1, 1, 1, 0, 0, 0, 64'h0, 16'h2};
    tv[4] = '{0, 0, 1, 16'h0004, 1, 0, 64'hB, 1,  1, 1, 1, 0, 0, 1, 64'hA, 16'h3};
    tv[5] = '{0, 0, 1, 16'h0055, 1, 0, 64'hC, 1,  1, 0, 1, 0, 0, 1, 64'hB, 16'h4};
    tv[6] = '{0, 0, 1, 16'h0055, 0, 1, 64'h0, 1,  1, 0, 1, 0, 0, 1, 64'hC, 16'h0};
    tv[7] = '{0, 0, 1, 16'h0055, 0, 0, 64'h0, 1,  1, 0, 0, 1, 1, 0, 64'h0, 16'h0};
    tv[8] = '{0, 0, 0, 16'h0000, 0, 0, 64'h0, 1,  0, 0, 0, 0, 0, 0, 64'h0, 16'h0};

    rst = 1'b1; start = 1'b0; cfg_len = '0; s_valid = 1'b0; s_data = '0;
    eng_dout = '0; eng_st_out = 1'b0; eng_done = 1'b0; m_ready = 1'b0;

    // ---------------- reset state ----------------
    @(negedge clk); #1;
    chk1("rst.busy", busy, 1'b0);
    chk1("rst.m_valid", m_valid, 1'b0);
    chk1("rst.s_ready", s_ready, 1'b0);
    chk1("rst.eng_rst", eng_rst, 1'b1);
    chk1("rst.eng_op_st", eng_op_st, 1'b0);
    chk1("rst.frame_done", frame_done, 1'b0);
    chk1("rst.ovf", ovf_err, 1'b0);
    chk1("rst.udr", udr_err, 1'b0);
    chk1("rst.tmo", tmo_err, 1'b0);
    chk("rst.res_cnt", 64'(res_cnt), 64'd0);
    rst = 1'b0;
    #1;
    chk1("rst_rel.eng_rst", eng_rst, 1'b0);

    // start with zero length is ignored
    @(negedge clk); start = 1'b1; cfg_len = 8'd0; #1;
    @(negedge clk); start = 1'b0; #1;
    chk1("len0.busy", busy, 1'b0);
    @(negedge clk); #1;
    chk1("len0.busy2", busy, 1'b0);

    // ---------------- nominal frame (table) ----------------
    hs = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      start = tv[i].start; cfg_len = tv[i].len; s_valid = tv[i].sv;
      s_data = mk_data(tv[i].sd); eng_st_out = tv[i].st; eng_done = tv[i].dn;
      eng_dout = tv[i].dout; m_ready = tv[i].mr;
      #1;
      chk1($sformatf("nom[%0d].busy", i), busy, tv[i].e_busy);
      chk1($sformatf("nom[%0d].s_ready", i), s_ready, tv[i].e_sr);
      chk1($sformatf("nom[%0d].eng_op_st", i), eng_op_st, tv[i].e_op);
      chk1($sformatf("nom[%0d].eng_rst", i), eng_rst, tv[i].e_erst);
      chk1($sformatf("nom[%0d].frame_done", i), frame_done, tv[i].e_fd);
      chk1($sformatf("nom[%0d].m_valid", i), m_valid, tv[i].e_mv);
      if (tv[i].e_mv) chk($sformatf("nom[%0d].m_data", i), m_data, tv[i].e_md);
      chk_lanes($sformatf("nom[%0d]", i), tv[i].e_a);
      if (s_ready && s_valid) hs++;
    end
    chk("nom.handshakes", 64'(hs), 64'd4);
    chk("nom.res_cnt", 64'(res_cnt), 64'd3);
    chk1("nom.udr", udr_err, 1'b0);

    // ---------------- underrun ----------------
    @(negedge clk); start = 1'b1; cfg_len = 8'd3; s_valid = 1'b1; s_data = mk_data(16'd5);
    eng_st_out = 1'b0; eng_done = 1'b0; m_ready = 1'b1; #1;
    @(negedge clk); start = 1'b0; #1;
    chk1("udr.beat1_ready", s_ready, 1'b1);
    @(negedge clk); s_valid = 1'b0; s_data = mk_data(16'h7777); #1;
    chk_lanes("udr.beat1", 16'd5);
    chk1("udr.flag_before", udr_err, 1'b0);
    @(negedge clk); s_valid = 1'b1; s_data = mk_data(16'd7); #1;
    chk_lanes("udr.beat2_zero", 16'd0);
    chk1("udr.flag_set", udr_err, 1'b1);
    chk1("udr.beat3_ready", s_ready, 1'b1);
    @(negedge clk); eng_done = 1'b1; #1;
    chk1("udr.drain_ready", s_ready, 1'b0);
    chk1("udr.drain_op", eng_op_st, 1'b1);
    chk_lanes("udr.beat3", 16'd7);
    @(negedge clk); eng_done = 1'b0; #1;
    chk1("udr.frame_done", frame_done, 1'b1);
    @(negedge clk); #1;
    chk1("udr.idle_busy", busy, 1'b0);
    chk1("udr.sticky", udr_err, 1'b1);

    // ---------------- overflow ----------------
    @(negedge clk); start = 1'b1; cfg_len = 8'd1; s_valid = 1'b1; s_data = mk_data(16'd9);
    m_ready = 1'b0; #1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk); start = 1'b0; eng_st_out = 1'b1; eng_dout = 64'(i); #1;
      if (i == 1) chk1("ovf.udr_cleared", udr_err, 1'b0);
      if (i == 9) begin
        chk1("ovf.before_9th", ovf_err, 1'b0);
        chk1("ovf.m_valid", m_valid, 1'b1);
        chk("ovf.head", m_data, 64'd1);
      end
    end
    @(negedge clk); eng_st_out = 1'b0; eng_done = 1'b1; #1;
    chk1("ovf.flag_set", ovf_err, 1'b1);
    @(negedge clk); eng_done = 1'b0; #1;
    chk1("ovf.frame_done", frame_done, 1'b1);
    @(negedge clk); #1;
    chk1("ovf.idle", busy, 1'b0);
    chk("ovf.idle_head", m_data, 64'd1);

    // full FIFO with simultaneous pop accepts the push
    @(negedge clk); start = 1'b1; cfg_len = 8'd1; #1;
    chk1("fullpop.ovf_sticky", ovf_err, 1'b1);
    @(negedge clk); start = 1'b0; eng_st_out = 1'b1; eng_dout = 64'h99; m_ready = 1'b1; #1;
    chk1("fullpop.ovf_cleared", ovf_err, 1'b0);
    chk("fullpop.head", m_data, 64'd1);
    @(negedge clk); eng_st_out = 1'b0; eng_done = 1'b1; m_ready = 1'b0; #1;
    chk1("fullpop.no_ovf", ovf_err, 1'b0);
    chk("fullpop.head2", m_data, 64'd2);
    @(negedge clk); eng_done = 1'b0; #1;
    chk1("fullpop.frame_done", frame_done, 1'b1);

    exp_q = '{64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd7, 64'd8, 64'h99};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); m_ready = 1'b1; #1;
      chk1($sformatf("drain[%0d].m_valid", i), m_valid, 1'b1);
      chk($sformatf("drain[%0d].m_data", i), m_data, exp_q[i]);
    end
    @(negedge clk); #1;
    chk1("drain.empty", m_valid, 1'b0);

    // ---------------- reset mid-LOAD ----------------
    @(negedge clk); start = 1'b1; cfg_len = 8'd4; s_valid = 1'b1; s_data = mk_data(16'd1);
    m_ready = 1'b0; #1;
    @(negedge clk); start = 1'b0; eng_st_out = 1'b1; eng_dout = 64'h77; #1;
    chk1("rml.beat1_ready", s_ready, 1'b1);
    @(negedge clk); eng_st_out = 1'b0; s_data = mk_data(16'd2); #1;
    chk1("rml.pushed", m_valid, 1'b1);
    rst = 1'b1; #1;
    chk1("rml.busy", busy, 1'b0);
    chk1("rml.m_valid", m_valid, 1'b0);
    chk1("rml.s_ready", s_ready, 1'b0);
    chk1("rml.eng_op_st", eng_op_st, 1'b0);
    chk1("rml.eng_rst", eng_rst, 1'b1);
    chk1("rml.frame_done", frame_done, 1'b0);
    chk_lanes("rml.lanes", 16'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk1("rml.after_busy", busy, 1'b0);
    chk1("rml.after_fd", frame_done, 1'b0);
    chk1("rml.after_mv", m_valid, 1'b0);
    @(negedge clk); #1;
    chk1("rml.after_fd2", frame_done, 1'b0);

    @(negedge clk); start = 1'b1; cfg_len = 8'd2; m_ready = 1'b1; #1;
    @(negedge clk); start = 1'b0; #1;
    chk1("rml2.beat1", s_ready, 1'b1);
    @(negedge clk); #1;
    chk1("rml2.beat2", s_ready, 1'b1);
    @(negedge clk); eng_done = 1'b1; #1;
    chk1("rml2.drain_ready", s_ready, 1'b0);
    chk1("rml2.drain_op", eng_op_st, 1'b1);
    @(negedge clk); eng_done = 1'b0; #1;
    chk1("rml2.frame_done", frame_done, 1'b1);
    chk1("rml2.eng_rst", eng_rst, 1'b1);
    @(negedge clk); #1;
    chk1("rml2.idle", busy, 1'b0);
    chk("rml2.res_cnt", 64'(res_cnt), 64'd0);

    // ---------------- DRAIN watchdog ----------------
`ifdef CONV_SEQ_TIMEOUT_EN
    @(negedge clk); start = 1'b1; cfg_len = 8'd1; #1;
    @(negedge clk); start = 1'b0; #1;
    chk1("tmo.load", s_ready, 1'b1);
    for (int d = 1; d <= 16; d++) begin
      @(negedge clk); #1;
      chk1($sformatf("tmo.drain[%0d].op", d), eng_op_st, 1'b1);
      chk1($sformatf("tmo.drain[%0d].fd", d), frame_done, 1'b0);
      if (d == 16) chk1("tmo.flag_before", tmo_err, 1'b0);
    end
    @(negedge clk); #1;
    chk1("tmo.frame_done", frame_done, 1'b1);
    chk1("tmo.flag", tmo_err, 1'b1);
    @(negedge clk); #1;
    chk1("tmo.idle", busy, 1'b0);
`else
    chk1("tmo.tied_low", tmo_err, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/conv_seq_ctrl.md
# conv_seq_ctrl

Frame sequencer for the 4-lane 64-tap convolution engine. It accepts a frame command and streams `cfg_len` four-lane input beats from a valid/ready source into the engine. It captures every valid engine result into a result FIFO drained by a valid/ready sink, then re-arms the engine with a one-cycle reset pulse. It sits between the AXI-facing wrapper (`myip`) and the engine instance.

## Interface
Parameters:
- `LEN_W`, 8 — width of the frame length field.
- `RES_DEPTH`, 8 — result FIFO depth; must be a power of 2, at least 2.
- `DRAIN_MAX`, 64 — watchdog limit in DRAIN, in cycles. Used only with `CONV_SEQ_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  frame request; sampled in IDLE only.
- `cfg_len`  in  LEN_W  input beats per frame; latched on accepted start.
- `busy`  out  1  high whenever state is not IDLE.
- `frame_done`  out  1  one-cycle pulse at end of frame.
- `s_valid` / `s_ready`  in / out  1 / 1  input beat handshake.
- `s_data`  in  64  four signed 16-bit lanes; lane0 = [63:48] … lane3 = [15:0].
- `eng_rst`  out  1  engine reset.
- `eng_op_st`  out  1  engine run.
- `eng_a0`..`eng_a3`  out  16 each  engine lane inputs.
- `eng_dout`  in  64  engine result.
- `eng_st_out`  in  1  engine result-valid.
- `eng_done`  in  1  engine done.
- `m_valid` / `m_ready` / `m_data`  out / in / out  1 / 1 / 64  result stream.
- `res_cnt`  out  LEN_W+1  results pushed this frame; saturates at all-ones.
- `ovf_err`, `udr_err`, `tmo_err`  out  1 each  sticky error flags.

## Operation
- States: IDLE → LOAD → DRAIN → CLEAR → IDLE.
- **IDLE:** `start`=1 with `cfg_len`≠0 latches the length, clears `res_cnt` and all error flags, and moves to LOAD. `start` with `cfg_len`=0 is ignored: no state change, no flag change.
- **LOAD:**
  - `eng_op_st`=1 and `s_ready`=1 every cycle.
  - Each cycle consumes one beat. If `s_valid`=1, the lanes are driven from `s_data`.
  - If `s_valid`=0, the lanes are driven to 0, `udr_err` is set, and the beat still counts. The engine cannot stall.
  - After `cfg_len` beats, go to DRAIN.
- **DRAIN:** `eng_op_st`=1, `s_ready`=0, lanes 0. `eng_done`=1 moves to CLEAR.
- **CLEAR:** one cycle only. `eng_op_st`=0, `eng_rst`=1, `frame_done`=1. Then IDLE.
- **Capture:**
  - In LOAD or DRAIN, any cycle with `eng_st_out`=1 and `eng_done`=0 pushes `eng_dout` into the FIFO and increments `res_cnt`.
  - Push when full: the word is dropped and `ovf_err` is set.
  - Full with a simultaneous pop: the push is accepted.
- **Result FIFO:** first-word fall-through, in-order. `m_data` is stable while `m_valid`=1 and `m_ready`=0. The FIFO keeps draining in IDLE; results are never discarded except on `rst`.
- **Outputs:**
  - `eng_rst` = `rst` OR (state == CLEAR).
  - All other outputs are registered, or decoded from registered state.
- **Reset:** all outputs 0 except `eng_rst`=1 (it follows `rst`). FIFO is emptied, state goes to IDLE. Asserting `rst` mid-frame aborts the frame with no `frame_done`.

## Timing
- Cycle 0: `start` accepted. Cycles 1..`cfg_len`: LOAD, with `eng_op_st` and `s_ready` high.
- Engine lanes are registered: `s_data` accepted in cycle n appears on `eng_a*` in cycle n+1.
- Capture to `m_valid`: 1 cycle (word pushed at edge n, `m_valid` high in cycle n+1 when the FIFO was empty).
- `busy` rises the cycle after `start` is accepted and falls the cycle after CLEAR.
- Minimum frame duration: `cfg_len` + 2 cycles plus the engine's done latency.
- `start` in any state other than IDLE is ignored.

## Configuration
- `CONV_SEQ_TIMEOUT_EN` defined: a DRAIN-cycle counter is compiled in. If it reaches `DRAIN_MAX` without `eng_done`, `tmo_err` is set and the state moves to CLEAR, giving a normal `frame_done` pulse.
- Not defined: DRAIN waits on `eng_done` indefinitely, and `tmo_err` is tied to 0.

## Structure
- Package `conv_seq_pkg`: state enum (IDLE, LOAD, DRAIN, CLEAR), lane width 16, lane count 4, result width 64.
- One sub-module, `conv_res_fifo`: parameterised FWFT FIFO with `full`, `empty`, `push`, `pop`; drops pushes when full unless a pop occurs in the same cycle.
- Lane registers, beat counter, watchdog and error flags stay in `conv_seq_ctrl`.

## Test plan
- **Reset:** assert `rst` → `busy`=0, `m_valid`=0, `s_ready`=0, `eng_rst`=1, all error flags 0. Then `start` with `cfg_len`=0 → `busy` stays 0.
- **Nominal frame:**
  - Stimulus: `cfg_len`=4, `s_valid` constantly 1, beats 0x0001…0x0004 per lane. Engine stub raises `eng_st_out` 2 cycles after `eng_op_st`, returns 3 results (0xA, 0xB, 0xC), then `eng_done`. `m_ready`=1.
  - Required: exactly 4 `s_ready` handshakes; `m_data` = A, B, C in order; `res_cnt`=3; one `frame_done` pulse coinciding with `eng_rst`=1.
- **Overflow:** `m_ready`=0 and the stub emits 9 results with `RES_DEPTH`=8 → 8 stored, 9th dropped, `ovf_err`=1. Raise `m_ready` → words 1..8 drained in order.
- **Underrun:** `cfg_len`=3, `s_valid` low on beat 2 → `eng_a0`..`eng_a3`=0 for that beat, `udr_err`=1, frame still ends after 3 beats.
- **Timeout (macro on):** `DRAIN_MAX`=16, stub never asserts `eng_done` → CLEAR after 16 DRAIN cycles, `tmo_err`=1, `frame_done` pulses.
- **Reset mid-LOAD:** assert `rst` on beat 2 of 4 → immediate IDLE, FIFO empty, no `frame_done`. A following start with `cfg_len`=2 completes normally.
